// File: rtl/taadda_pkg.sv
// Shared TAADDA CPU definitions: default datapath sizes and the register-bank range check.
package taadda_pkg;

    localparam int unsigned TAADDA_DATA_W = 8;
    localparam int unsigned TAADDA_REGS   = 8;

    function automatic logic reg_bank_addr_valid(input int unsigned addr,
                                                 input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/reg_bank_rd_port.sv
// One read port of reg_bank: address mux with range check, optional write bypass, and
// enable gating so disabled ports drive zero onto OR-merged buses.
module reg_bank_rd_port
    import taadda_pkg::*;
#(
    parameter int unsigned WIDTH  = TAADDA_DATA_W,
    parameter int unsigned DEPTH  = TAADDA_REGS,
    parameter bit          BYPASS = 1'b1,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] regs,
    input  logic                        en,
    input  logic [ADDR_W-1:0]           addr,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    output logic [WIDTH-1:0]            data
);

    logic [WIDTH-1:0] stored;
    logic             addr_ok;
    logic             hit;

    assign addr_ok = reg_bank_addr_valid(32'(addr), DEPTH);
    assign hit     = BYPASS && wr_en && addr_ok && (wr_addr == addr);

    // Loop mux keeps out-of-range addresses from indexing past the array.
    always_comb begin
        stored = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (32'(addr) == i) begin
                stored = regs[i];
            end
        end
    end

    always_comb begin
        data = '0;
        if (en) begin
            data = hit ? wr_data : stored;
        end
    end

endmodule

// File: rtl/reg_bank.sv
// Parametrised register bank: one write port, two gated read ports, an ungated monitor
// port and a per-cycle increment channel with registered wrap flag.
module reg_bank
    import taadda_pkg::*;
#(
    parameter int unsigned WIDTH       = TAADDA_DATA_W,
    parameter int unsigned DEPTH       = TAADDA_REGS,
    parameter bit          BYPASS      = 1'b1,
    parameter logic [63:0] RESET_VALUE = 64'd0,
    localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              inc_en,
    input  logic [ADDR_W-1:0] inc_addr,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    input  logic [ADDR_W-1:0] mon_addr,
    output logic [WIDTH-1:0]  mon_data,
    output logic              inc_wrap
);

    localparam logic [WIDTH-1:0] RstVal = RESET_VALUE[WIDTH-1:0];

    logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
    logic                        inc_wrap_q, inc_wrap_d;
    logic                        wr_ok, inc_ok;
    logic [WIDTH-1:0]            inc_old;
    logic                        byp_en;

    assign wr_ok  = wr_en && reg_bank_addr_valid(32'(wr_addr), DEPTH);
    // A write to the same register wins over the increment.
    assign inc_ok = inc_en && reg_bank_addr_valid(32'(inc_addr), DEPTH)
                    && !(wr_ok && (wr_addr == inc_addr));

    always_comb begin
        inc_old = '0;
        regs_d  = regs_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (32'(inc_addr) == i) begin
                inc_old = regs_q[i];
            end
            if (wr_ok && (32'(wr_addr) == i)) begin
                regs_d[i] = wr_data;
            end else if (inc_ok && (32'(inc_addr) == i)) begin
                regs_d[i] = regs_q[i] + WIDTH'(1);
            end
        end
        inc_wrap_d = inc_ok && (&inc_old);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q     <= {DEPTH{RstVal}};
            inc_wrap_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            inc_wrap_q <= inc_wrap_d;
        end
    end

    assign inc_wrap = inc_wrap_q;

    // No bypass while reset holds the array at its reset value.
    assign byp_en = wr_en && rst;

    reg_bank_rd_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .BYPASS(BYPASS)
    ) u_rd_a (
        .regs   (regs_q),
        .en     (rd_en_a),
        .addr   (rd_addr_a),
        .wr_en  (byp_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .data   (rd_data_a)
    );

    reg_bank_rd_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .BYPASS(BYPASS)
    ) u_rd_b (
        .regs   (regs_q),
        .en     (rd_en_b),
        .addr   (rd_addr_b),
        .wr_en  (byp_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .data   (rd_data_b)
    );

    reg_bank_rd_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .BYPASS(1'b0)
    ) u_mon (
        .regs   (regs_q),
        .en     (1'b1),
        .addr   (mon_addr),
        .wr_en  (byp_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .data   (mon_data)
    );

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: three instances (bypass, no-bypass, 16x5) checked every cycle
// against an array model, plus directed literal expectations.
module tb_reg_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en, inc_en, rd_en_a, rd_en_b;
    logic [2:0] wr_addr, inc_addr, rd_addr_a, rd_addr_b, mon_addr;
    logic [7:0] wr_data;
    logic [15:0] wr_data16;

    logic [7:0]  a_rd_a, a_rd_b, a_mon, n_rd_a, n_rd_b, n_mon;
    logic [15:0] c_rd_a, c_rd_b, c_mon;
    logic        a_wrap, n_wrap, c_wrap;

    int vectors = 0;
    int errors  = 0;
    bit cmp_en  = 1'b0;

    logic [7:0]  m8 [8];
    logic [15:0] m16[8];
    logic        w8, w16;

    always #5 clk = ~clk;

    reg_bank u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .inc_en(inc_en), .inc_addr(inc_addr),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(a_rd_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(a_rd_b),
        .mon_addr(mon_addr), .mon_data(a_mon), .inc_wrap(a_wrap)
    );

    reg_bank #(.BYPASS(1'b0)) u_n (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .inc_en(inc_en), .inc_addr(inc_addr),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(n_rd_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(n_rd_b),
        .mon_addr(mon_addr), .mon_data(n_mon), .inc_wrap(n_wrap)
    );

    reg_bank #(.WIDTH(16), .DEPTH(5)) u_c (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data16),
        .inc_en(inc_en), .inc_addr(inc_addr),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(c_rd_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(c_rd_b),
        .mon_addr(mon_addr), .mon_data(c_mon), .inc_wrap(c_wrap)
    );

    // Model: registers 0..7 for the 8x8 banks, 0..4 meaningful for the 16x5 bank.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            foreach (m8[i]) m8[i] <= 8'h00;
            foreach (m16[i]) m16[i] <= 16'h0000;
            w8  <= 1'b0;
            w16 <= 1'b0;
        end else begin
            w8  <= 1'b0;
            w16 <= 1'b0;
            if (inc_en && !(wr_en && wr_addr == inc_addr)) begin
                m8[inc_addr] <= m8[inc_addr] + 8'd1;
                w8 <= (m8[inc_addr] == 8'hFF);
            end
            if (inc_en && inc_addr < 3'd5 && !(wr_en && wr_addr == inc_addr)) begin
                m16[inc_addr] <= m16[inc_addr] + 16'd1;
                w16 <= (m16[inc_addr] == 16'hFFFF);
            end
            if (wr_en) m8[wr_addr] <= wr_data;
            if (wr_en && wr_addr < 3'd5) m16[wr_addr] <= wr_data16;
        end
    end

    function automatic logic [15:0] exp8(input logic en, input logic [2:0] addr,
                                         input logic byp);
        if (!en) return 16'h0000;
        if (byp && rst && wr_en && wr_addr == addr) return {8'h00, wr_data};
        return {8'h00, m8[addr]};
    endfunction

    function automatic logic [15:0] exp16(input logic en, input logic [2:0] addr);
        if (!en || addr >= 3'd5) return 16'h0000;
        if (rst && wr_en && wr_addr == addr) return wr_data16;
        return m16[addr];
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("a.rd_a", {8'h00, a_rd_a}, exp8(rd_en_a, rd_addr_a, 1'b1));
            chk("a.rd_b", {8'h00, a_rd_b}, exp8(rd_en_b, rd_addr_b, 1'b1));
            chk("a.mon", {8'h00, a_mon}, exp8(1'b1, mon_addr, 1'b0));
            chk("a.wrap", {15'h0, a_wrap}, {15'h0, w8});
            chk("n.rd_a", {8'h00, n_rd_a}, exp8(rd_en_a, rd_addr_a, 1'b0));
            chk("n.rd_b", {8'h00, n_rd_b}, exp8(rd_en_b, rd_addr_b, 1'b0));
            chk("n.mon", {8'h00, n_mon}, exp8(1'b1, mon_addr, 1'b0));
            chk("n.wrap", {15'h0, n_wrap}, {15'h0, w8});
            chk("c.rd_a", c_rd_a, exp16(rd_en_a, rd_addr_a));
            chk("c.rd_b", c_rd_b, exp16(rd_en_b, rd_addr_b));
            chk("c.mon", c_mon, (mon_addr < 3'd5) ? m16[mon_addr] : 16'h0000);
            chk("c.wrap", {15'h0, c_wrap}, {15'h0, w16});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [7:0] d8, input logic [15:0] d16);
        wr_en = 1'b1;
        wr_addr = addr;
        wr_data = d8;
        wr_data16 = d16;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        wr_en = 0; inc_en = 0; rd_en_a = 0; rd_en_b = 0;
        wr_addr = 0; inc_addr = 0; rd_addr_a = 0; rd_addr_b = 0; mon_addr = 0;
        wr_data = 0; wr_data16 = 0;
        #1 rst = 1'b0;
        #1 cmp_en = 1'b1;
        tick; tick;
        chk("reset.mon", {8'h00, a_mon}, 16'h0000);
        chk("reset.wrap", {15'h0, a_wrap}, 16'h0000);
        rst = 1'b1;

        // Reset mid-operation
        wr(3'd3, 8'h5A, 16'h005A); mon_addr = 3'd3;
        tick; wr_en = 0;
        chk("wr.mon3", {8'h00, a_mon}, 16'h005A);
        @(negedge clk); #1;
        rd_en_a = 0; rd_addr_a = 3'd3;
        #1 rst = 1'b0;
        #1;
        chk("rstmid.mon3", {8'h00, a_mon}, 16'h0000);
        chk("rstmid.wrap", {15'h0, a_wrap}, 16'h0000);
        chk("rstmid.rd_a_off", {8'h00, a_rd_a}, 16'h0000);
        rd_en_a = 1;
        #1 chk("rstmid.rd_a_on", {8'h00, a_rd_a}, 16'h0000);
        wr(3'd5, 8'h77, 16'h0077); inc_en = 1; inc_addr = 3'd3; rd_addr_a = 3'd5;
        #1 chk("rstmid.nobyp", {8'h00, a_rd_a}, 16'h0000);
        tick;
        wr_en = 0; inc_en = 0; rst = 1'b1; mon_addr = 3'd5;
        #1 chk("rstmid.wr_dropped", {8'h00, a_mon}, 16'h0000);
        mon_addr = 3'd3;
        #1 chk("rstmid.inc_dropped", {8'h00, a_mon}, 16'h0000);

        // Read gating and bypass
        wr(3'd2, 8'h11, 16'h0011);
        tick;
        wr(3'd2, 8'h22, 16'h0022);
        rd_en_a = 1; rd_addr_a = 3'd2; rd_en_b = 0; rd_addr_b = 3'd2; mon_addr = 3'd2;
        #1;
        chk("byp.a", {8'h00, a_rd_a}, 16'h0022);
        chk("byp.b_off", {8'h00, a_rd_b}, 16'h0000);
        chk("nobyp.a", {8'h00, n_rd_a}, 16'h0011);
        chk("byp.mon_old", {8'h00, a_mon}, 16'h0011);
        tick; wr_en = 0;
        chk("byp.mon_new", {8'h00, a_mon}, 16'h0022);
        rd_en_b = 1;

        // Increment wrap
        wr(3'd7, 8'hFE, 16'h00FE);
        tick; wr_en = 0;
        inc_en = 1; inc_addr = 3'd7; mon_addr = 3'd7;
        tick;
        chk("inc.ff", {8'h00, a_mon}, 16'h00FF);
        chk("inc.wrap0", {15'h0, a_wrap}, 16'h0000);
        tick;
        chk("inc.00", {8'h00, a_mon}, 16'h0000);
        chk("inc.wrap1", {15'h0, a_wrap}, 16'h0001);
        tick; inc_en = 0;
        chk("inc.01", {8'h00, a_mon}, 16'h0001);
        chk("inc.wrap_clr", {15'h0, a_wrap}, 16'h0000);
        chk("inc.c_oor", {15'h0, c_wrap}, 16'h0000);
        tick;

        // Write/increment collision
        wr(3'd1, 8'hFF, 16'h00FF); tick;
        wr(3'd4, 8'h09, 16'h0009); tick;
        wr(3'd1, 8'h40, 16'h0040); inc_en = 1; inc_addr = 3'd1;
        tick; wr_en = 0; inc_en = 0; mon_addr = 3'd1;
        #1;
        chk("coll.same", {8'h00, a_mon}, 16'h0040);
        chk("coll.wrap", {15'h0, a_wrap}, 16'h0000);
        wr(3'd1, 8'hFF, 16'h00FF); tick;
        wr(3'd1, 8'h40, 16'h0040); inc_en = 1; inc_addr = 3'd4;
        tick; wr_en = 0; inc_en = 0; rd_addr_a = 3'd4;
        #1;
        chk("coll.diff_w", {8'h00, a_mon}, 16'h0040);
        chk("coll.diff_i", {8'h00, a_rd_a}, 16'h000A);

        // Non-power-of-two depth
        for (int i = 0; i < 5; i++) begin
            wr(3'(i), 8'(i), 16'h1000 + 16'(i));
            tick;
        end
        wr(3'd6, 8'h66, 16'hBEEF); rd_en_a = 1; rd_addr_a = 3'd6;
        inc_en = 1; inc_addr = 3'd7;
        #1 chk("oor.rd_same_cycle", c_rd_a, 16'h0000);
        tick; wr_en = 0; inc_en = 0;
        chk("oor.rd_after", c_rd_a, 16'h0000);
        chk("oor.wrap", {15'h0, c_wrap}, 16'h0000);
        @(negedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            mon_addr = 3'(i);
            #1 chk("oor.unchanged", c_mon, 16'h1000 + 16'(i));
        end
        wr(3'd4, 8'h04, 16'hFFFF); tick;
        wr_en = 0; inc_en = 1; inc_addr = 3'd4;
        tick; inc_en = 0; mon_addr = 3'd4;
        #1;
        chk("c.wrap_val", c_mon, 16'h0000);
        chk("c.wrap_flag", {15'h0, c_wrap}, 16'h0001);
        tick; tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
